// File: rtl/id_serialize_sequencer.sv
// rtl/id_serialize_sequencer.sv - decode-stage serializing-instruction sequencer (drain, notify, fetch freeze)
// Optional statistics counters enabled by defining ID_SERIALIZE_STATS_EN.
module id_serialize_sequencer #(
  parameter int NUM_SLOTS    = 2,
  parameter int DRAIN_CYCLES = 4,
  parameter int CNT_W        = 4
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic [NUM_SLOTS-1:0] Slot_Valid_IN,
  input  logic [NUM_SLOTS-1:0] Slot_Serialize_IN,
  input  logic [NUM_SLOTS-1:0] Slot_NotifySim_IN,
  input  logic                 Stall_IN,
  output logic [NUM_SLOTS-1:0] Slot_Pass_OUT,
  output logic [NUM_SLOTS-1:0] Slot_Marker_OUT,
  output logic                 SYS,
  output logic                 WANT_FREEZE,
`ifdef ID_SERIALIZE_STATS_EN
  output logic [15:0]          Serialize_Count_OUT,
  output logic [15:0]          Squash_Count_OUT,
`endif
  output logic                 Busy_OUT
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRAIN  = 2'd1,
    NOTIFY = 2'd2
  } state_t;

  state_t               state_q, state_n;
  logic [CNT_W-1:0]     cnt_q, cnt_n;
  logic                 notify_q, notify_n;
  logic [NUM_SLOTS-1:0] pass_n, marker_n;
  logic                 sys_n;

  logic [NUM_SLOTS-1:0] ser_vec;
  logic [NUM_SLOTS-1:0] oldest_onehot;
  logic [NUM_SLOTS-1:0] older_mask;
  logic                 hit;
  logic                 notify_k;

  // Lowest set bit isolates the oldest serializing slot; everything below it is older.
  always_comb begin
    ser_vec       = Slot_Valid_IN & Slot_Serialize_IN;
    hit           = |ser_vec;
    oldest_onehot = ser_vec & (~ser_vec + NUM_SLOTS'(1));
    older_mask    = oldest_onehot - NUM_SLOTS'(1);
    notify_k      = |(oldest_onehot & Slot_NotifySim_IN);
  end

  always_comb begin
    state_n     = state_q;
    cnt_n       = cnt_q;
    notify_n    = notify_q;
    pass_n      = '0;
    marker_n    = '0;
    sys_n       = 1'b0;
    WANT_FREEZE = 1'b0;
    case (state_q)
      IDLE: begin
        WANT_FREEZE = hit;
        if (hit) begin
          pass_n   = Slot_Valid_IN & older_mask;
          marker_n = oldest_onehot;
          notify_n = notify_k;
          cnt_n    = CNT_W'(DRAIN_CYCLES);
          state_n  = DRAIN;
        end else begin
          pass_n = Slot_Valid_IN;
        end
      end
      DRAIN: begin
        WANT_FREEZE = 1'b1;
        if (cnt_q > CNT_W'(1)) begin
          cnt_n = cnt_q - CNT_W'(1);
        end else begin
          cnt_n   = '0;
          sys_n   = notify_q;
          state_n = NOTIFY;
        end
      end
      NOTIFY: begin
        // Freeze stays low here so fetch can step past the serializing instruction.
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q         <= IDLE;
      cnt_q           <= '0;
      notify_q        <= 1'b0;
      Slot_Pass_OUT   <= '0;
      Slot_Marker_OUT <= '0;
      SYS             <= 1'b0;
      Busy_OUT        <= 1'b0;
    end else if (!Stall_IN) begin
      state_q         <= state_n;
      cnt_q           <= cnt_n;
      notify_q        <= notify_n;
      Slot_Pass_OUT   <= pass_n;
      Slot_Marker_OUT <= marker_n;
      SYS             <= sys_n;
      Busy_OUT        <= (state_n != IDLE);
    end
  end

`ifdef ID_SERIALIZE_STATS_EN
  logic [NUM_SLOTS-1:0] squash_vec;
  logic [15:0]          squash_pop;
  logic [16:0]          squash_sum;

  always_comb begin
    squash_vec = '0;
    if (state_q == IDLE) begin
      if (hit) squash_vec = Slot_Valid_IN & ~(oldest_onehot | older_mask);
    end else begin
      squash_vec = Slot_Valid_IN;
    end
    squash_pop = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      squash_pop = squash_pop + 16'(squash_vec[i]);
    end
    squash_sum = {1'b0, Squash_Count_OUT} + {1'b0, squash_pop};
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      Serialize_Count_OUT <= '0;
      Squash_Count_OUT    <= '0;
    end else if (!Stall_IN) begin
      if (state_q == IDLE && hit) Serialize_Count_OUT <= Serialize_Count_OUT + 16'd1;
      Squash_Count_OUT <= squash_sum[16] ? 16'hFFFF : squash_sum[15:0];
    end
  end
`endif

endmodule

// File: tb/tb_id_serialize_sequencer.sv
// tb/tb_id_serialize_sequencer.sv - directed scoreboard bench for id_serialize_sequencer
module tb_id_serialize_sequencer;

  logic       CLK;
  logic       RESET;
  logic [1:0] Slot_Valid_IN;
  logic [1:0] Slot_Serialize_IN;
  logic [1:0] Slot_NotifySim_IN;
  logic       Stall_IN;
  logic [1:0] Slot_Pass_OUT;
  logic [1:0] Slot_Marker_OUT;
  logic       SYS;
  logic       WANT_FREEZE;
  logic       Busy_OUT;
`ifdef ID_SERIALIZE_STATS_EN
  logic [15:0] Serialize_Count_OUT;
  logic [15:0] Squash_Count_OUT;
`endif

  id_serialize_sequencer #(.NUM_SLOTS(2), .DRAIN_CYCLES(4), .CNT_W(4)) dut (
    .CLK               (CLK),
    .RESET             (RESET),
    .Slot_Valid_IN     (Slot_Valid_IN),
    .Slot_Serialize_IN (Slot_Serialize_IN),
    .Slot_NotifySim_IN (Slot_NotifySim_IN),
    .Stall_IN          (Stall_IN),
    .Slot_Pass_OUT     (Slot_Pass_OUT),
    .Slot_Marker_OUT   (Slot_Marker_OUT),
    .SYS               (SYS),
    .WANT_FREEZE       (WANT_FREEZE),
`ifdef ID_SERIALIZE_STATS_EN
    .Serialize_Count_OUT (Serialize_Count_OUT),
    .Squash_Count_OUT    (Squash_Count_OUT),
`endif
    .Busy_OUT          (Busy_OUT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [1:0] pass;
    logic [1:0] marker;
    logic       sys;
    logic       busy;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   sys_cycles[$];
  logic sys_prev = 1'b0;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of stimulus, check freeze combinationally, then score the registered outputs.
  task automatic step(input string tag, input logic [1:0] v, input logic [1:0] s, input logic [1:0] n,
                      input logic st, input logic fz, input logic [1:0] p, input logic [1:0] m,
                      input logic sy, input logic bu);
    exp_t e;
    Slot_Valid_IN     = v;
    Slot_Serialize_IN = s;
    Slot_NotifySim_IN = n;
    Stall_IN          = st;
    #1;
    check({tag, ".freeze"}, 16'(WANT_FREEZE), 16'(fz));
    sb.push_back('{pass: p, marker: m, sys: sy, busy: bu});
    @(posedge CLK);
    #1;
    cyc++;
    if (SYS === 1'b1 && sys_prev !== 1'b1) sys_cycles.push_back(cyc);
    sys_prev = SYS;
    if (sb.size() == 0) begin
      check({tag, ".scoreboard_empty"}, 16'd0, 16'd1);
    end else begin
      e = sb.pop_front();
      check({tag, ".pass"},   16'(Slot_Pass_OUT),   16'(e.pass));
      check({tag, ".marker"}, 16'(Slot_Marker_OUT), 16'(e.marker));
      check({tag, ".sys"},    16'(SYS),             16'(e.sys));
      check({tag, ".busy"},   16'(Busy_OUT),        16'(e.busy));
    end
    @(negedge CLK);
  endtask

  initial begin
    RESET = 1'b0;
    Slot_Valid_IN = '0;
    Slot_Serialize_IN = '0;
    Slot_NotifySim_IN = '0;
    Stall_IN = 1'b0;
    #3;
    check("reset.pass",   16'(Slot_Pass_OUT),   16'd0);
    check("reset.marker", 16'(Slot_Marker_OUT), 16'd0);
    check("reset.sys",    16'(SYS),             16'd0);
    check("reset.busy",   16'(Busy_OUT),        16'd0);
    check("reset.freeze", 16'(WANT_FREEZE),     16'd0);
    @(negedge CLK);
    RESET = 1'b1;

    // Plain flow and an ignored serialize flag on an invalid slot
    for (int i = 0; i < 3; i++) step("plain", 2'b11, 2'b00, 2'b00, 0, 0, 2'b11, 2'b00, 0, 0);
    step("inval_ser", 2'b01, 2'b10, 2'b10, 0, 0, 2'b01, 2'b00, 0, 0);

    // Syscall in slot 0
    step("sc0.hit", 2'b11, 2'b01, 2'b01, 0, 1, 2'b00, 2'b01, 0, 1);
    for (int i = 0; i < 3; i++) step("sc0.drain", 2'b11, 2'b00, 2'b00, 0, 1, 2'b00, 2'b00, 0, 1);
    step("sc0.drain_last", 2'b11, 2'b00, 2'b00, 0, 1, 2'b00, 2'b00, 1, 1);
    step("sc0.notify", 2'b11, 2'b00, 2'b00, 0, 0, 2'b00, 2'b00, 0, 0);
    step("sc0.idle", 2'b11, 2'b00, 2'b00, 0, 0, 2'b11, 2'b00, 0, 0);

    // LL/SC in slot 1: slot 0 passes, no SYS, freeze inhibited in NOTIFY despite a hit
    step("ll1.hit", 2'b11, 2'b10, 2'b00, 0, 1, 2'b01, 2'b10, 0, 1);
    for (int i = 0; i < 4; i++) step("ll1.drain", 2'b11, 2'b00, 2'b00, 0, 1, 2'b00, 2'b00, 0, 1);
    step("ll1.notify", 2'b11, 2'b01, 2'b01, 0, 0, 2'b00, 2'b00, 0, 0);
    step("ll1.idle", 2'b11, 2'b00, 2'b00, 0, 0, 2'b11, 2'b00, 0, 0);

    // Stall mid-DRAIN at counter=2 and during NOTIFY
    step("stl.hit", 2'b01, 2'b01, 2'b01, 0, 1, 2'b00, 2'b01, 0, 1);
    step("stl.d4", 2'b00, 2'b00, 2'b00, 0, 1, 2'b00, 2'b00, 0, 1);
    step("stl.d3", 2'b00, 2'b00, 2'b00, 0, 1, 2'b00, 2'b00, 0, 1);
    for (int i = 0; i < 3; i++) step("stl.hold", 2'b11, 2'b01, 2'b01, 1, 1, 2'b00, 2'b00, 0, 1);
    step("stl.d2", 2'b00, 2'b00, 2'b00, 0, 1, 2'b00, 2'b00, 0, 1);
    step("stl.d1", 2'b00, 2'b00, 2'b00, 0, 1, 2'b00, 2'b00, 1, 1);
    step("stl.notify_hold", 2'b11, 2'b00, 2'b00, 1, 0, 2'b00, 2'b00, 1, 1);
    step("stl.notify", 2'b00, 2'b00, 2'b00, 0, 0, 2'b00, 2'b00, 0, 0);

    // Back-to-back syscalls with no dead cycle
    sys_cycles.delete();
    step("b2b.hit1", 2'b11, 2'b01, 2'b01, 0, 1, 2'b00, 2'b01, 0, 1);
    for (int i = 0; i < 3; i++) step("b2b.drain1", 2'b00, 2'b00, 2'b00, 0, 1, 2'b00, 2'b00, 0, 1);
    step("b2b.last1", 2'b00, 2'b00, 2'b00, 0, 1, 2'b00, 2'b00, 1, 1);
    step("b2b.notify1", 2'b00, 2'b00, 2'b00, 0, 0, 2'b00, 2'b00, 0, 0);
    step("b2b.hit2", 2'b01, 2'b01, 2'b01, 0, 1, 2'b00, 2'b01, 0, 1);
    for (int i = 0; i < 3; i++) step("b2b.drain2", 2'b00, 2'b00, 2'b00, 0, 1, 2'b00, 2'b00, 0, 1);
    step("b2b.last2", 2'b00, 2'b00, 2'b00, 0, 1, 2'b00, 2'b00, 1, 1);
    check("b2b.sys_pulses", 16'(sys_cycles.size()), 16'd2);
    if (sys_cycles.size() >= 2)
      check("b2b.sys_spacing", 16'(sys_cycles[1] - sys_cycles[0]), 16'd6);
`ifdef ID_SERIALIZE_STATS_EN
    check("stats.ser_count", Serialize_Count_OUT, 16'd5);
`endif

    // Async reset while SYS is high
    check("rst.sys_before", 16'(SYS), 16'd1);
    RESET = 1'b0;
    #1;
    check("rst.sys",    16'(SYS),             16'd0);
    check("rst.busy",   16'(Busy_OUT),        16'd0);
    check("rst.pass",   16'(Slot_Pass_OUT),   16'd0);
    check("rst.marker", 16'(Slot_Marker_OUT), 16'd0);
`ifdef ID_SERIALIZE_STATS_EN
    check("rst.ser_count", Serialize_Count_OUT, 16'd0);
`endif
    @(negedge CLK);
    RESET = 1'b1;
    step("post_rst", 2'b10, 2'b00, 2'b00, 0, 0, 2'b10, 2'b00, 0, 0);
    check("sb.drained", 16'(sb.size()), 16'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
